float_addsub_pipe: RTL and testbench

- Pipelined, parametrised IEEE-754-style floating-point adder/subtractor; the successor to the combinational single-precision add/sub cell in the NN datapath.
- Generalises the format widths and adds round-to-nearest-even, special-value handling, overflow/underflow flags, tag passthrough and valid/ready backpressure.
- Sits between the MAC accumulator and the activation unit. Accepts one operation per clock when not stalled.

---
 rtl/float_addsub_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_float_addsub_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with round-to-nearest-even,
// flush-to-zero, special-value handling and valid/ready backpressure.
module float_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   input  logic                   in_op,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_sum,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   out_ovf,
   output logic                   out_unf
);
   localparam int W       = EXP_W + MAN_W + 1;
   localparam int MW      = MAN_W + 4;
   localparam int XW      = EXP_W + 2;
   localparam int EXP_TOP = (1 << EXP_W) - 1;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   // ---------------- handshake ----------------
   logic v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
   logic adv1, adv2, adv3, ld1, ld2, ld3;

   always_comb begin
      adv3 = out_ready | ~v3_q;
      adv2 = adv3 | ~v2_q;
      adv1 = adv2 | ~v1_q;
      v1_d = adv1 ? in_valid : v1_q;
      v2_d = adv2 ? v1_q : v2_q;
      v3_d = adv3 ? v2_q : v3_q;
      ld1  = adv1 & in_valid;
      ld2  = adv2 & v1_q;
      ld3  = adv3 & v2_q;
   end

   assign in_ready = adv1;

   // ---------------- S1: classify, swap, align ----------------
   logic                   a_s, b_s, b_es;
   logic [EXP_W-1:0]       a_e, b_e, big_e, sml_e, diff;
   logic [MAN_W-1:0]       a_f, b_f;
   logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
   logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
   logic [MAN_W:0]         big_m, sml_m;
   logic [2*MW-1:0]        sml_wide;
   int                     shamt;

   logic                   s1_spec_d, s1_spec_q, s1_sign_d, s1_sign_q, s1_sub_d, s1_sub_q;
   logic [W-1:0]           s1_val_d, s1_val_q;
   logic [EXP_W-1:0]       s1_exp_d, s1_exp_q;
   logic [MW-1:0]          s1_big_d, s1_big_q, s1_sml_d, s1_sml_q;
   logic [TAG_W-1:0]       s1_tag_q;

   assign {a_s, a_e, a_f} = in_a;
   assign {b_s, b_e, b_f} = in_b;

   always_comb begin
      a_zero = (a_e == '0);
      b_zero = (b_e == '0);
      a_inf  = (a_e == EXP_ONES) && (a_f == '0);
      b_inf  = (b_e == EXP_ONES) && (b_f == '0);
      a_nan  = (a_e == EXP_ONES) && (a_f != '0);
      b_nan  = (b_e == EXP_ONES) && (b_f != '0);
      b_es   = b_s ^ in_op;
      // Denormal fractions are masked so they compare and align as true zeros.
      a_mag  = {a_e, a_f & {MAN_W{~a_zero}}};
      b_mag  = {b_e, b_f & {MAN_W{~b_zero}}};
      swap   = (b_mag > a_mag);
      big_e  = swap ? b_e : a_e;
      sml_e  = swap ? a_e : b_e;
      big_m  = swap ? {~b_zero, b_mag[MAN_W-1:0]} : {~a_zero, a_mag[MAN_W-1:0]};
      sml_m  = swap ? {~a_zero, a_mag[MAN_W-1:0]} : {~b_zero, b_mag[MAN_W-1:0]};
      diff   = big_e - sml_e;
      shamt  = (int'(diff) > MW) ? MW : int'(diff);
      // Lower half of the wide shift collects everything pushed past the sticky bit.
      sml_wide  = {sml_m, 3'b000, {MW{1'b0}}} >> shamt;
      s1_sml_d  = {sml_wide[2*MW-1:MW+1], sml_wide[MW] | (|sml_wide[MW-1:0])};
      s1_big_d  = {big_m, 3'b000};
      s1_exp_d  = big_e;
      s1_sign_d = swap ? b_es : a_s;
      s1_sub_d  = a_s ^ b_es;

      s1_spec_d = 1'b1;
      s1_val_d  = '0;
      if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_es))) begin
         s1_val_d = QNAN;
      end else if (a_inf) begin
         s1_val_d = {a_s, EXP_ONES, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         s1_val_d = {b_es, EXP_ONES, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
         s1_val_d = {a_s & b_es, {(W-1){1'b0}}};
      end else begin
         s1_spec_d = 1'b0;
      end
   end

   // ---------------- S2: add/subtract and normalise ----------------
   logic [MW:0]             sum;
   int                      lz, e2;
   logic                    s2_spec_d, s2_spec_q, s2_sign_q, s2_zero_d, s2_zero_q;
   logic [MW-1:0]           s2_norm_d, s2_norm_q;
   logic signed [XW-1:0]    s2_exp_d, s2_exp_q;
   logic [W-1:0]            s2_val_q;
   logic [TAG_W-1:0]        s2_tag_q;

   always_comb begin
      sum = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_sml_q})
                     : ({1'b0, s1_big_q} + {1'b0, s1_sml_q});
      lz = MW;
      for (int i = 0; i < MW; i++) begin
         if (sum[i]) lz = MW - 1 - i;
      end
      if (sum[MW]) begin
         s2_norm_d = {sum[MW:2], sum[1] | sum[0]};
         e2        = int'(s1_exp_q) + 1;
      end else begin
         s2_norm_d = sum[MW-1:0] << lz;
         e2        = int'(s1_exp_q) - lz;
      end
      s2_exp_d  = XW'(e2);
      s2_zero_d = (sum == '0);
      s2_spec_d = s1_spec_q;
   end

   // ---------------- S3: round, range check, output register ----------------
   logic                    rnd;
   logic [MAN_W+1:0]        mant;
   logic [MAN_W-1:0]        frac3;
   int                      e3;
   logic [W-1:0]            s3_sum_d, s3_sum_q;
   logic                    s3_ovf_d, s3_ovf_q, s3_unf_d, s3_unf_q;
   logic [TAG_W-1:0]        s3_tag_q;

   always_comb begin
      rnd   = s2_norm_q[2] & (s2_norm_q[1] | s2_norm_q[0] | s2_norm_q[3]);
      mant  = {1'b0, s2_norm_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd};
      e3    = int'(s2_exp_q) + (mant[MAN_W+1] ? 1 : 0);
      frac3 = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
      s3_ovf_d = 1'b0;
      s3_unf_d = 1'b0;
      if (s2_spec_q) begin
         s3_sum_d = s2_val_q;
      end else if (s2_zero_q) begin
         s3_sum_d = '0;
      end else if (e3 >= EXP_TOP) begin
         s3_sum_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
         s3_ovf_d = 1'b1;
      end else if (e3 <= 0) begin
         s3_sum_d = {s2_sign_q, {(W-1){1'b0}}};
         s3_unf_d = 1'b1;
      end else begin
         s3_sum_d = {s2_sign_q, e3[EXP_W-1:0], frac3};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         v3_q     <= 1'b0;
         s3_sum_q <= '0;
         s3_tag_q <= '0;
         s3_ovf_q <= 1'b0;
         s3_unf_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         if (ld3) begin
            s3_sum_q <= s3_sum_d;
            s3_tag_q <= s2_tag_q;
            s3_ovf_q <= s3_ovf_d;
            s3_unf_q <= s3_unf_d;
         end
      end
   end

   // NOTE: inner datapath flops have no reset; their contents are only observed behind a valid bit.
   always_ff @(posedge clk) begin
      if (ld1) begin
         s1_spec_q <= s1_spec_d;
         s1_val_q  <= s1_val_d;
         s1_sign_q <= s1_sign_d;
         s1_sub_q  <= s1_sub_d;
         s1_exp_q  <= s1_exp_d;
         s1_big_q  <= s1_big_d;
         s1_sml_q  <= s1_sml_d;
         s1_tag_q  <= in_tag;
      end
      if (ld2) begin
         s2_spec_q <= s2_spec_d;
         s2_val_q  <= s1_val_q;
         s2_sign_q <= s1_sign_q;
         s2_zero_q <= s2_zero_d;
         s2_norm_q <= s2_norm_d;
         s2_exp_q  <= s2_exp_d;
         s2_tag_q  <= s1_tag_q;
      end
   end

   assign out_valid = v3_q;
   assign out_sum   = s3_sum_q;
   assign out_tag   = s3_tag_q;
   assign out_ovf   = s3_ovf_q;
   assign out_unf   = s3_unf_q;

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Scoreboard bench for float_addsub_pipe: directed IEEE cases plus random traffic
// checked against a double-precision reference with single-precision RNE repacking.
module tb_float_addsub_pipe;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int TAG_W = 4;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_op, out_valid, out_ready, out_ovf, out_unf;
   logic [31:0] in_a, in_b, out_sum;
   logic [3:0]  in_tag, out_tag;

   typedef struct packed {
      logic [31:0] sum;
      logic [3:0]  tag;
      logic        ovf;
      logic        unf;
   } res_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] s;
      logic        ovf;
      logic        unf;
   } vec_t;

   res_t sb[$];
   res_t exp_cur;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_out    = 0;
   int   cyc      = 0;

   float_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_tag(out_tag), .out_ovf(out_ovf), .out_unf(out_unf)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic real f32_to_real(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0)       d = {x[31], 63'd0};
      else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'd0};
      else                        d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Exact-enough reference: double sum of two singles, then RNE to 24 bits with flush-to-zero.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic op, input logic [3:0] tag);
      res_t        r;
      real         x;
      logic [63:0] d;
      logic [52:0] m;
      logic [28:0] rest;
      logic [24:0] m24;
      logic        up;
      int          e;
      r.tag = tag;
      r.ovf = 1'b0;
      r.unf = 1'b0;
      x = op ? (f32_to_real(a) - f32_to_real(b)) : (f32_to_real(a) + f32_to_real(b));
      d = $realtobits(x);
      if (d[62:52] == 11'h7FF) begin
         r.sum = (d[51:0] != 52'd0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'd0};
      end else if (d[62:52] == 11'd0) begin
         r.sum = {d[63], 31'd0};
      end else begin
         e    = int'(d[62:52]) - 896;
         m    = {1'b1, d[51:0]};
         rest = m[28:0];
         m24  = {1'b0, m[52:29]};
         up   = (rest > 29'h10000000) || ((rest == 29'h10000000) && m24[0]);
         m24  = m24 + 25'(up);
         if (m24[24]) begin
            e++;
            m24 = m24 >> 1;
         end
         if (e >= 255) begin
            r.sum = {d[63], 8'hFF, 23'd0};
            r.ovf = 1'b1;
         end else if (e <= 0) begin
            r.sum = {d[63], 31'd0};
            r.unf = 1'b1;
         end else begin
            r.sum = {d[63], 8'(e), m24[22:0]};
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] rnd_f();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
   endfunction

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [3:0] tag, input res_t e);
      logic acc;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_tag   = tag;
      exp_cur  = e;
      acc      = 1'b0;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      check("accept", 64'(acc), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_rnd(input logic [3:0] tag);
      logic [31:0] a, b;
      logic        op;
      a  = rnd_f();
      b  = rnd_f();
      op = 1'($urandom_range(0, 1));
      send(a, b, op, tag, model(a, b, op, tag));
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: samples at the falling edge, pushes on acceptance, pops on delivery.
   initial begin
      logic        held;
      logic [31:0] held_sum;
      logic [3:0]  held_tag;
      res_t        e;
      held = 1'b0;
      held_sum = '0;
      held_tag = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            held = 1'b0;
         end else begin
            if (held) begin
               check("stall_valid", out_valid, 1);
               check("stall_sum", out_sum, held_sum);
               check("stall_tag", out_tag, held_tag);
            end
            if (out_valid && out_ready) begin
               check("result_expected", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("sum", out_sum, e.sum);
                  check("tag", out_tag, e.tag);
                  check("ovf", out_ovf, e.ovf);
                  check("unf", out_unf, e.unf);
               end
               n_out++;
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
            held     = out_valid && !out_ready;
            held_sum = out_sum;
            held_tag = out_tag;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   vec_t vecs [16] = '{
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0},
      '{32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 1'b0, 1'b0},
      '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0},
      '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0},
      '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0},
      '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1},
      '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0},
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0},
      '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 1'b0, 1'b0},
      '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0},
      '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1, 1'b0},
      '{32'h3F800000, 32'hBF800001, 1'b0, 32'hB4000000, 1'b0, 1'b0}
   };

   initial begin
      int lat, t0, n_target;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = 1'b0;
      in_tag    = '0;
      out_ready = 1'b1;
      exp_cur   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_out_unf", out_unf, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // First-result latency.
      send(32'h3F800000, 32'h40000000, 1'b0, 4'd5, '{sum: 32'h40400000, tag: 4'd5, ovf: 1'b0, unf: 1'b0});
      lat = 0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (out_valid) lat = i;
      end
      check("latency", 64'(lat), 64'd3);
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].op, 4'(i),
              '{sum: vecs[i].s, tag: 4'(i), ovf: vecs[i].ovf, unf: vecs[i].unf});
      end
      drain();

      // Backpressure: output held off for five cycles, then random.
      out_ready = 1'b0;
      n_target  = n_out + 8;
      fork
         begin
            for (int k = 0; k < 8; k++) send_rnd(4'(k + 8));
         end
         begin
            repeat (5) @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
            for (int i = 0; i < 400 && n_out < n_target; i++) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", 64'(n_out), 64'(n_target));

      // Reset with three operations in flight.
      for (int k = 0; k < 3; k++) send_rnd(4'(k));
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_sum", out_sum, 0);
      @(posedge clk);
      #1;
      send(32'h3F800000, 32'h40000000, 1'b0, 4'd9, model(32'h3F800000, 32'h40000000, 1'b0, 4'd9));
      for (int k = 0; k < 3; k++) send_rnd(4'(k + 12));
      drain();

      // Full throughput with out_ready held high.
      t0 = cyc;
      for (int k = 0; k < 16; k++) send_rnd(4'(k));
      check("throughput_cycles", 64'(cyc - t0), 64'd16);
      drain();
      repeat (5) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
